// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
// The bus interface instance must be built with the same WIDTH as this module.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic             accept;
  logic [WIDTH-1:0] res_cat;

  // Full-subtractor cell on the current LSBs, plus accept qualification.
  always_comb begin
    ai      = a_sh[0];
    bi      = b_sh[0];
    d       = ai ^ bi ^ br;
    br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
    accept  = bus.start && (state != RUN);
    // Partial result keeps only WIDTH-1 bits; the final bit joins it on the
    // last cycle, so the concatenation is both the shift input and the result.
    res_cat = {d, res};
  end

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          res  <= res_cat[WIDTH-1:1];
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q   <= res_cat;
            borrow_q <= br_nxt;
            ovf_q    <= (a_msb != b_msb) && (d != a_msb);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 scenarios plus a WIDTH=4 sweep.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation from an idle/done state, with latency, busy-length,
  // result and single-pulse checks.
  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] dexp, input logic bexp, input logic oexp);
    int n;
    int nb;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    n  = 0;
    nb = 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      if (bus8.busy === 1'b1) nb++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_busycyc"}, 32'(nb), 32'd8);
    chk({tag, "_diff"}, 32'(bus8.diff), 32'(dexp));
    chk({tag, "_borrow"}, 32'(bus8.borrow_out), 32'(bexp));
    chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(oexp));
    chk({tag, "_busy_at_done"}, 32'(bus8.busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    chk({tag, "_diff_hold"}, 32'(bus8.diff), 32'(dexp));
  endtask

  initial begin
    int n;
    int extra;
    int sa;
    int sb;
    int r;
    logic [3:0] av4;
    logic [3:0] bv4;

    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;

    // Reset state
    #8;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_diff", 32'(bus8.diff), 32'd0);
    chk("rst_borrow", 32'(bus8.borrow_out), 32'd0);
    chk("rst_ovf", 32'(bus8.ovf), 32'd0);
    #4;
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(bus8.busy), 32'd0);

    // Basic and boundary operands
    run_op8("t1_5m3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op8("t2_3m5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op8("t2_80m1", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op8("t2_0m0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // start and operand changes while busy are ignored
    bus8.a     = 8'h05;
    bus8.b     = 8'h03;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    bus8.a     = 8'hFF;
    bus8.b     = 8'hFF;
    bus8.start = 1'b1;
    tick();
    tick();
    bus8.start = 1'b0;
    n = 4;
    while (bus8.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd8);
    chk("t3_diff", 32'(bus8.diff), 32'h02);
    chk("t3_borrow", 32'(bus8.borrow_out), 32'd0);
    chk("t3_ovf", 32'(bus8.ovf), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1) extra++;
    end
    chk("t3_extra_done", 32'(extra), 32'd0);
    chk("t3_idle_busy", 32'(bus8.busy), 32'd0);

    // start held through DONE: back-to-back with no bubble
    bus8.a     = 8'h30;
    bus8.b     = 8'h10;
    bus8.start = 1'b1;
    tick();
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    n = 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_first_latency", 32'(n), 32'd8);
    chk("t4_first_diff", 32'(bus8.diff), 32'h20);
    chk("t4_first_borrow", 32'(bus8.borrow_out), 32'd0);
    tick();
    bus8.start = 1'b0;
    n = 1;
    chk("t4_rerun_busy", 32'(bus8.busy), 32'd1);
    chk("t4_rerun_done", 32'(bus8.done), 32'd0);
    chk("t4_diff_not_cleared", 32'(bus8.diff), 32'h20);
    while (bus8.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_done_spacing", 32'(n), 32'd9);
    chk("t4_second_diff", 32'(bus8.diff), 32'hF0);
    chk("t4_second_borrow", 32'(bus8.borrow_out), 32'd1);
    chk("t4_second_ovf", 32'(bus8.ovf), 32'd0);
    tick();

    // Asynchronous reset in the middle of a run
    bus8.a     = 8'h55;
    bus8.b     = 8'h11;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_busy", 32'(bus8.busy), 32'd0);
    chk("t5_async_done", 32'(bus8.done), 32'd0);
    chk("t5_async_diff", 32'(bus8.diff), 32'd0);
    chk("t5_async_borrow", 32'(bus8.borrow_out), 32'd0);
    chk("t5_async_ovf", 32'(bus8.ovf), 32'd0);
    tick();
    #2;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
    end
    chk("t5_stays_idle", 32'(extra), 32'd0);
    run_op8("t5_Am4", 8'h0A, 8'h04, 8'h06, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep against an arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        av4 = 4'(ia);
        bv4 = 4'(ib);
        bus4.a     = av4;
        bus4.b     = bv4;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        n = 0;
        while (bus4.done !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        r  = sa - sb;
        chk("t6_latency", 32'(n), 32'd4);
        chk("t6_diff", 32'(bus4.diff), 32'((ia - ib) & 15));
        chk("t6_borrow", 32'(bus4.borrow_out), (ia < ib) ? 32'd1 : 32'd0);
        chk("t6_ovf", 32'(bus4.ovf), (r > 7 || r < -8) ? 32'd1 : 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
